// File: rtl/march_bist.sv
// ---------------------------------------------------------------------------
// march_bist
//
// Memory BIST controller running MATS+ or March C- over a banked SRAM array.
// The linear address A = {bank, word} sweeps 0..N-1, N = 2^(BANK_W+ADDR_W).
// Every memory operation takes two cycles: SETUP (address and data driven,
// strobes idle) then STROBE (chip-select / output-enable pulsed). Read data
// comes back the cycle after a read STROBE and is compared there against the
// expected value registered at STROBE.
//
// Optional feature: define MARCH_BIST_FAIL_LOG_EN to keep the first
// LOG_DEPTH failing addresses in detection order, readable through
// LOG_RD_IDX / LOG_RD_ADDR. Without the macro LOG_RD_ADDR is tied to 0.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   BIST_START          start request (only honoured in IDLE)
//   BIST_ABORT          abort a running test, fail status is kept
//   BIST_MODE           0 = MATS+, 1 = March C-, latched at start
//   BIST_ODATA          read data from the selected bank
//   MEM_ADDR            word address within a bank
//   MEM_ODATA_SELECT    bank index for the read-data mux
//   MEM_CE, MEM_WEB     strobe, write enable (0 = write)
//   MEM_CSB, MEM_OEB    one-hot-low bank chip-select / output-enable
//   MEM_IDATA           write data
//   BIST_BUSY           test in progress
//   BIST_DONE           one-cycle completion pulse
//   BIST_FAIL           sticky fail flag
//   FAIL_ADDR           first failing {bank, word}
//   FAIL_CNT            saturating fail count
//   LOG_RD_IDX          fail-log read index
//   LOG_RD_ADDR         fail-log entry (combinational read)
// ---------------------------------------------------------------------------
module march_bist #(
   parameter int ADDR_W    = 10,
   parameter int BANK_W    = 6,
   parameter int DATA_W    = 8,
   parameter int LOG_DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       BIST_START,
   input  logic                       BIST_ABORT,
   input  logic                       BIST_MODE,
   input  logic [DATA_W-1:0]          BIST_ODATA,
   output logic [ADDR_W-1:0]          MEM_ADDR,
   output logic [BANK_W-1:0]          MEM_ODATA_SELECT,
   output logic                       MEM_CE,
   output logic                       MEM_WEB,
   output logic [(1<<BANK_W)-1:0]     MEM_CSB,
   output logic [(1<<BANK_W)-1:0]     MEM_OEB,
   output logic [DATA_W-1:0]          MEM_IDATA,
   output logic                       BIST_BUSY,
   output logic                       BIST_DONE,
   output logic                       BIST_FAIL,
   output logic [BANK_W+ADDR_W-1:0]   FAIL_ADDR,
   output logic [7:0]                 FAIL_CNT,
   input  logic [3:0]                 LOG_RD_IDX,
   output logic [BANK_W+ADDR_W-1:0]   LOG_RD_ADDR
);

   localparam int NB   = 1 << BANK_W;
   localparam int LA_W = BANK_W + ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_FLUSH,
      S_DONE
   } state_e;

   // One march element: direction and up to two ops. When an element has
   // two ops the first is always a read and the second always a write.
   typedef struct packed {
      logic down;
      logic two_ops;
      logic first_rd;
      logic first_val;
      logic second_val;
   } elem_t;

   function automatic logic elem_down(input logic mode, input logic [2:0] idx);
      return mode ? (idx == 3'd3 || idx == 3'd4) : (idx == 3'd2);
   endfunction

   function automatic elem_t elem_info(input logic mode, input logic [2:0] idx);
      elem_t e;
      e      = '0;
      e.down = elem_down(mode, idx);
      if (!mode) begin
         // MATS+: w0 ; r0,w1 ; r1,w0
         case (idx)
            3'd1:    begin e.two_ops = 1'b1; e.first_rd = 1'b1; e.first_val = 1'b0; e.second_val = 1'b1; end
            3'd2:    begin e.two_ops = 1'b1; e.first_rd = 1'b1; e.first_val = 1'b1; e.second_val = 1'b0; end
            default: ;  // element 0: single w0
         endcase
      end else begin
         // March C-: w0 ; r0,w1 ; r1,w0 ; r0,w1 ; r1,w0 ; r0
         case (idx)
            3'd1, 3'd3: begin e.two_ops = 1'b1; e.first_rd = 1'b1; e.first_val = 1'b0; e.second_val = 1'b1; end
            3'd2, 3'd4: begin e.two_ops = 1'b1; e.first_rd = 1'b1; e.first_val = 1'b1; e.second_val = 1'b0; end
            3'd5:       begin e.first_rd = 1'b1; end
            default:    ;  // element 0: single w0
         endcase
      end
      return e;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e              state_q, state_d;
   logic                mode_q, mode_d;
   logic [2:0]          elem_q, elem_d;
   logic [LA_W-1:0]     addr_q, addr_d;
   logic                opi_q, opi_d;           // op index within element
   logic                cmp_vld_q, cmp_vld_d;   // compare pending this cycle
   logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
   logic [LA_W-1:0]     cmp_addr_q, cmp_addr_d;
   logic                fail_q, fail_d;
   logic [LA_W-1:0]     fail_addr_q, fail_addr_d;
   logic [7:0]          fail_cnt_q, fail_cnt_d;

   logic                log_clr;
   logic                log_wr;

   // ------------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------------
   elem_t               cur;
   logic                nxt_down;
   logic [2:0]          last_elem;
   logic                op_rd;
   logic [DATA_W-1:0]   op_data;
   logic                addr_end;
   logic [BANK_W-1:0]   bank;
   logic [NB-1:0]       bank_oh;
   logic                active;
   logic                abort_act;
   logic                mismatch;

   // NOTE: every signal driven from always_comb gets a default at the top so
   // no path through the case statements leaves it unassigned (no latches).
   always_comb begin
      cur       = elem_info(mode_q, elem_q);
      nxt_down  = elem_down(mode_q, elem_q + 3'd1);
      last_elem = mode_q ? 3'd5 : 3'd2;
      op_rd     = !opi_q && cur.first_rd;
      op_data   = {DATA_W{opi_q ? cur.second_val : cur.first_val}};
      addr_end  = cur.down ? (addr_q == '0) : (addr_q == '1);
      bank      = addr_q[LA_W-1 -: BANK_W];
      bank_oh   = '0;
      bank_oh[bank] = 1'b1;
      active    = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_FLUSH);
      abort_act = BIST_ABORT && active;
      mismatch  = cmp_vld_q && (BIST_ODATA != cmp_exp_q);
   end

   always_comb begin
      state_d          = state_q;
      mode_d           = mode_q;
      elem_d           = elem_q;
      addr_d           = addr_q;
      opi_d            = opi_q;
      cmp_vld_d        = 1'b0;
      cmp_exp_d        = cmp_exp_q;
      cmp_addr_d       = cmp_addr_q;
      fail_d           = fail_q;
      fail_addr_d      = fail_addr_q;
      fail_cnt_d       = fail_cnt_q;
      log_clr          = 1'b0;
      log_wr           = 1'b0;

      MEM_ADDR         = '0;
      MEM_ODATA_SELECT = '0;
      MEM_IDATA        = '0;
      MEM_CE           = 1'b0;
      MEM_WEB          = 1'b1;
      MEM_CSB          = '1;
      MEM_OEB          = '1;
      BIST_BUSY        = active;
      BIST_DONE        = (state_q == S_DONE);

      // Result of the read strobed last cycle. An abort in the same cycle
      // throws it away.
      if (mismatch && !abort_act) begin
         fail_d = 1'b1;
         if (!fail_q) begin
            fail_addr_d = cmp_addr_q;
         end
         if (fail_cnt_q != 8'hFF) begin
            fail_cnt_d = fail_cnt_q + 8'd1;
         end
         log_wr = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (BIST_START) begin
               state_d     = S_SETUP;
               mode_d      = BIST_MODE;
               elem_d      = '0;
               addr_d      = '0;          // element 0 always runs up
               opi_d       = 1'b0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_cnt_d  = '0;
               log_clr     = 1'b1;
            end
         end

         S_SETUP: begin
            MEM_ADDR         = addr_q[ADDR_W-1:0];
            MEM_ODATA_SELECT = bank;
            MEM_IDATA        = op_data;
            state_d          = abort_act ? S_IDLE : S_STROBE;
         end

         S_STROBE: begin
            MEM_ADDR         = addr_q[ADDR_W-1:0];
            MEM_ODATA_SELECT = bank;
            MEM_IDATA        = op_data;
            MEM_CE           = 1'b1;
            MEM_CSB          = ~bank_oh;
            if (op_rd) begin
               MEM_OEB = ~bank_oh;
            end else begin
               MEM_WEB = 1'b0;
            end

            if (abort_act) begin
               state_d = S_IDLE;
            end else begin
               cmp_vld_d  = op_rd;
               cmp_exp_d  = op_data;
               cmp_addr_d = addr_q;
               state_d    = S_SETUP;
               if (cur.two_ops && !opi_q) begin
                  opi_d = 1'b1;
               end else begin
                  opi_d = 1'b0;
                  if (addr_end) begin
                     if (elem_q == last_elem) begin
                        state_d = S_FLUSH;
                     end else begin
                        // Element boundary: reload for the next direction.
                        elem_d = elem_q + 3'd1;
                        addr_d = nxt_down ? '1 : '0;
                     end
                  end else begin
                     addr_d = cur.down ? addr_q - LA_W'(1) : addr_q + LA_W'(1);
                  end
               end
            end
         end

         S_FLUSH: begin
            state_d = abort_act ? S_IDLE : S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         elem_q      <= '0;
         addr_q      <= '0;
         opi_q       <= 1'b0;
         cmp_vld_q   <= 1'b0;
         cmp_exp_q   <= '0;
         cmp_addr_q  <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         elem_q      <= elem_d;
         addr_q      <= addr_d;
         opi_q       <= opi_d;
         cmp_vld_q   <= cmp_vld_d;
         cmp_exp_q   <= cmp_exp_d;
         cmp_addr_q  <= cmp_addr_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_cnt_q  <= fail_cnt_d;
      end
   end

   assign BIST_FAIL = fail_q;
   assign FAIL_ADDR = fail_addr_q;
   assign FAIL_CNT  = fail_cnt_q;

   // ------------------------------------------------------------------------
   // Optional fail log
   // ------------------------------------------------------------------------
`ifdef MARCH_BIST_FAIL_LOG_EN
   logic [LA_W-1:0] log_q [LOG_DEPTH];
   logic [4:0]      log_cnt_q;

   // NOTE: the log array is cleared on reset and at start because unwritten
   // entries must read as zero; it is small enough to live in flops.
   always_ff @(posedge CLK) begin
      if (RST || log_clr) begin
         for (int i = 0; i < LOG_DEPTH; i++) begin
            log_q[i] <= '0;
         end
         log_cnt_q <= '0;
      end else if (log_wr && (log_cnt_q < 5'(LOG_DEPTH))) begin
         for (int i = 0; i < LOG_DEPTH; i++) begin
            if (log_cnt_q == 5'(i)) begin
               log_q[i] <= cmp_addr_q;
            end
         end
         log_cnt_q <= log_cnt_q + 5'd1;
      end
   end

   always_comb begin
      LOG_RD_ADDR = '0;
      for (int i = 0; i < LOG_DEPTH; i++) begin
         if ((LOG_RD_IDX == 4'(i)) && (5'(i) < log_cnt_q)) begin
            LOG_RD_ADDR = log_q[i];
         end
      end
   end
`else
   logic log_unused;
   assign log_unused  = ^{LOG_RD_IDX, log_clr, log_wr};
   assign LOG_RD_ADDR = '0;
`endif

endmodule

// File: tb/tb_march_bist.sv
module tb_march_bist;

   localparam int ADDR_W    = 2;
   localparam int BANK_W    = 1;
   localparam int DATA_W    = 8;
   localparam int LOG_DEPTH = 4;
   localparam int NB        = 2;
   localparam int N         = 8;

   logic                CLK = 1'b0;
   logic                RST = 1'b1;
   logic                BIST_START = 1'b0;
   logic                BIST_ABORT = 1'b0;
   logic                BIST_MODE  = 1'b0;
   logic [DATA_W-1:0]   BIST_ODATA;
   logic [ADDR_W-1:0]   MEM_ADDR;
   logic [BANK_W-1:0]   MEM_ODATA_SELECT;
   logic                MEM_CE;
   logic                MEM_WEB;
   logic [NB-1:0]       MEM_CSB;
   logic [NB-1:0]       MEM_OEB;
   logic [DATA_W-1:0]   MEM_IDATA;
   logic                BIST_BUSY;
   logic                BIST_DONE;
   logic                BIST_FAIL;
   logic [2:0]          FAIL_ADDR;
   logic [7:0]          FAIL_CNT;
   logic [3:0]          LOG_RD_IDX = 4'd0;
   logic [2:0]          LOG_RD_ADDR;

   always #5 CLK = ~CLK;

   march_bist #(
      .ADDR_W(ADDR_W), .BANK_W(BANK_W), .DATA_W(DATA_W), .LOG_DEPTH(LOG_DEPTH)
   ) dut (
      .CLK(CLK), .RST(RST),
      .BIST_START(BIST_START), .BIST_ABORT(BIST_ABORT), .BIST_MODE(BIST_MODE),
      .BIST_ODATA(BIST_ODATA),
      .MEM_ADDR(MEM_ADDR), .MEM_ODATA_SELECT(MEM_ODATA_SELECT),
      .MEM_CE(MEM_CE), .MEM_WEB(MEM_WEB), .MEM_CSB(MEM_CSB), .MEM_OEB(MEM_OEB),
      .MEM_IDATA(MEM_IDATA),
      .BIST_BUSY(BIST_BUSY), .BIST_DONE(BIST_DONE), .BIST_FAIL(BIST_FAIL),
      .FAIL_ADDR(FAIL_ADDR), .FAIL_CNT(FAIL_CNT),
      .LOG_RD_IDX(LOG_RD_IDX), .LOG_RD_ADDR(LOG_RD_ADDR)
   );

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- memory model with stuck-at-1 on bit 0 ----------------
   logic [7:0]    mem [N];
   logic [N-1:0]  sa1 = '0;
   logic [7:0]    rdata = 8'h00;
   logic [2:0]    mla;
   logic [NB-1:0] sel_low;

   assign mla        = {MEM_ODATA_SELECT, MEM_ADDR};
   assign sel_low    = ~(2'b01 << MEM_ODATA_SELECT);
   assign BIST_ODATA = rdata;

   initial begin
      for (int i = 0; i < N; i++) mem[i] = 8'h3C ^ 8'(i);
   end

   always @(posedge CLK) begin
      if (MEM_CE) begin
         if (!MEM_WEB && MEM_CSB == sel_low && MEM_OEB == 2'b11)
            mem[mla] <= MEM_IDATA;
         else if (MEM_WEB && MEM_CSB == sel_low && MEM_OEB == sel_low)
            rdata <= mem[mla] | {7'b0, sa1[mla]};
         else
            rdata <= 8'hA5;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int         done_at;
      int         busy;
      logic       fail;
      logic [2:0] faddr;
      logic [7:0] fcnt;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   done_seen = 0;
   int   busy_cnt = 0;
   int   s = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: the completion pulse is the DUT's output event.
   always @(negedge CLK) begin : monitor
      exp_t e;
      if (BIST_DONE === 1'b1) begin
         done_seen++;
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(BIST_DONE), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("done_cycle",  cyc,             e.done_at);
            check("busy_cycles", busy_cnt,        e.busy);
            check("fail_flag",   32'(BIST_FAIL),  32'(e.fail));
            check("fail_addr",   32'(FAIL_ADDR),  32'(e.faddr));
            check("fail_cnt",    32'(FAIL_CNT),   32'(e.fcnt));
         end
         busy_cnt = 0;
      end else if (BIST_BUSY === 1'b1) begin
         busy_cnt++;
      end else begin
         busy_cnt = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic kick(input logic mode);
      @(negedge CLK);
      BIST_MODE  = mode;
      BIST_START = 1'b1;
      s = cyc;
      @(negedge CLK);
      BIST_START = 1'b0;
   endtask

   task automatic launch(input logic mode, input logic fail, input logic [2:0] faddr,
                         input logic [7:0] fcnt, input int done_rel);
      exp_t e;
      @(negedge CLK);
      BIST_MODE  = mode;
      BIST_START = 1'b1;
      s = cyc;
      e.done_at = s + done_rel;
      e.busy    = done_rel - 1;
      e.fail    = fail;
      e.faddr   = faddr;
      e.fcnt    = fcnt;
      sb_q.push_back(e);
      @(negedge CLK);
      BIST_START = 1'b0;
   endtask

   task automatic goto(input int rel);
      while (cyc < s + rel) @(negedge CLK);
   endtask

   task automatic wait_done();
      int old = done_seen;
      int k = 0;
      while (done_seen == old && k < 400) begin
         @(negedge CLK);
         k++;
      end
      if (done_seen == old) check("done_timeout", 32'(done_seen - old), 32'd1);
      @(negedge CLK);
      check("done_pulse_width", 32'(BIST_DONE), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ce"},        32'(MEM_CE),           32'd0);
      check({tag, "_web"},       32'(MEM_WEB),          32'd1);
      check({tag, "_csb"},       32'(MEM_CSB),          32'd3);
      check({tag, "_oeb"},       32'(MEM_OEB),          32'd3);
      check({tag, "_addr"},      32'(MEM_ADDR),         32'd0);
      check({tag, "_sel"},       32'(MEM_ODATA_SELECT), 32'd0);
      check({tag, "_idata"},     32'(MEM_IDATA),        32'd0);
      check({tag, "_busy"},      32'(BIST_BUSY),        32'd0);
      check({tag, "_done"},      32'(BIST_DONE),        32'd0);
      check({tag, "_fail"},      32'(BIST_FAIL),        32'd0);
      check({tag, "_fail_addr"}, 32'(FAIL_ADDR),        32'd0);
      check({tag, "_fail_cnt"},  32'(FAIL_CNT),         32'd0);
   endtask

   task automatic check_log(input logic [3:0] idx, input logic [2:0] exp_on);
      LOG_RD_IDX = idx;
      #1;
`ifdef MARCH_BIST_FAIL_LOG_EN
      check("log_entry", 32'(LOG_RD_ADDR), 32'(exp_on));
`else
      check("log_tied_zero", 32'(LOG_RD_ADDR), 32'd0 & 32'(exp_on));
`endif
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      check_reset_vals("por");

      // Fault-free runs.
      launch(1'b0, 1'b0, 3'd0, 8'd0, 82);  wait_done();
      launch(1'b1, 1'b0, 3'd0, 8'd0, 162); wait_done();

      // Stuck-at-1 bit 0 at A=5.
      sa1 = 8'b0010_0000;
      launch(1'b0, 1'b1, 3'd5, 8'd1, 82);  wait_done();
      launch(1'b1, 1'b1, 3'd5, 8'd3, 162); wait_done();
      check_log(4'd2, 3'd5);
      check_log(4'd3, 3'd0);

      // Stuck-at-1 at A=2,3,6: only the first four fails are logged.
      sa1 = 8'b0100_1100;
      launch(1'b1, 1'b1, 3'd2, 8'd9, 162); wait_done();
      check_log(4'd0, 3'd2);
      check_log(4'd1, 3'd3);
      check_log(4'd2, 3'd6);
      check_log(4'd3, 3'd6);
      check_log(4'd5, 3'd0);

      // START and MODE changes during a run are ignored.
      sa1 = '0;
      launch(1'b0, 1'b0, 3'd0, 8'd0, 82);
      goto(10); BIST_START = 1'b1; BIST_MODE = 1'b1;
      goto(11); BIST_START = 1'b0;
      wait_done();

      // Abort in cycle 20: idle in 21, no completion pulse.
      kick(1'b0);
      goto(20); BIST_ABORT = 1'b1;
      goto(21);
      check("abort_busy", 32'(BIST_BUSY), 32'd0);
      check("abort_csb",  32'(MEM_CSB),   32'd3);
      check("abort_oeb",  32'(MEM_OEB),   32'd3);
      check("abort_ce",   32'(MEM_CE),    32'd0);
      BIST_ABORT = 1'b0;
      repeat (100) @(negedge CLK);
      check("abort_stays_idle", 32'(BIST_BUSY), 32'd0);

      // Abort in the compare cycle of the faulty read discards it.
      sa1 = 8'b0010_0000;
      kick(1'b0);
      goto(39); BIST_ABORT = 1'b1;
      goto(40); BIST_ABORT = 1'b0;
      check("abort_discard_fail", 32'(BIST_FAIL), 32'd0);
      check("abort_discard_cnt",  32'(FAIL_CNT),  32'd0);

      // Abort after the fail was recorded keeps it.
      kick(1'b0);
      goto(40); BIST_ABORT = 1'b1;
      goto(41); BIST_ABORT = 1'b0;
      check("abort_keep_fail", 32'(BIST_FAIL), 32'd1);
      check("abort_keep_addr", 32'(FAIL_ADDR), 32'd5);
      check("abort_keep_cnt",  32'(FAIL_CNT),  32'd1);
      check("abort_keep_busy", 32'(BIST_BUSY), 32'd0);

      // Reset pulse mid-test after a fail at A=1.
      sa1 = 8'b0000_0010;
      kick(1'b0);
      goto(29);
      check("pre_rst_fail_addr", 32'(FAIL_ADDR), 32'd1);
      goto(30); RST = 1'b1;
      goto(31); RST = 1'b0;
      check_reset_vals("mid_rst");
      check_log(4'd0, 3'd0);

      // Clean run after reset.
      sa1 = '0;
      launch(1'b0, 1'b0, 3'd0, 8'd0, 82); wait_done();

      repeat (5) @(negedge CLK);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
